// File: rtl/zap_fetch_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
package zap_fetch_queue_pkg;

  // One fetched packet as it travels from fetch to decode.
  typedef struct packed {
    logic [31:0] instruction;
    logic        abort;
    logic [31:0] pc;
    logic [31:0] pc_plus_8;
    logic [1:0]  taken;
  } fq_pkt_t;

  localparam int FQ_PKT_W = $bits(fq_pkt_t);

  // NORMAL accepts packets; DRAIN refuses new packets after an aborted fetch
  // until the pipeline is cleared.
  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } fq_state_e;

endpackage

// File: rtl/zap_fetch_queue.sv
// Fetch/decode decoupling queue with show-ahead head and abort drain mode.
module zap_fetch_queue
  import zap_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_clear,
  input  logic                       i_wr_valid,
  output logic                       o_wr_ready,
  input  logic [31:0]                i_wr_instruction,
  input  logic                       i_wr_abort,
  input  logic [31:0]                i_wr_pc,
  input  logic [31:0]                i_wr_pc_plus_8,
  input  logic [1:0]                 i_wr_taken,
  output logic                       o_rd_valid,
  input  logic                       i_rd_ready,
  output logic [31:0]                o_rd_instruction,
  output logic                       o_rd_abort,
  output logic [31:0]                o_rd_pc,
  output logic [31:0]                o_rd_pc_plus_8,
  output logic [1:0]                 o_rd_taken,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  fq_state_e     state_q, state_d;
  fq_pkt_t       mem_q [DEPTH];

  fq_pkt_t       wr_pkt;
  fq_pkt_t       head;
  logic          empty, full;
  logic          wr_fire, rd_fire;

  assign wr_pkt = '{instruction: i_wr_instruction, abort: i_wr_abort, pc: i_wr_pc,
                    pc_plus_8: i_wr_pc_plus_8, taken: i_wr_taken};

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Ready is purely registered: a same-cycle read never opens a slot.
  assign o_wr_ready = !full && (state_q == NORMAL);
  assign o_rd_valid = !empty;
  assign o_level    = wr_ptr_q - rd_ptr_q;

  assign wr_fire = i_wr_valid && o_wr_ready;
  assign rd_fire = o_rd_valid && i_rd_ready;

  // Show-ahead head packet straight from the register array.
  assign head             = mem_q[rd_ptr_q[AW-1:0]];
  assign o_rd_instruction = head.instruction;
  assign o_rd_abort       = head.abort;
  assign o_rd_pc          = head.pc;
  assign o_rd_pc_plus_8   = head.pc_plus_8;
  assign o_rd_taken       = head.taken;

  // Pointer next-state: clear collapses both pointers and drops any transfer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Drain FSM next-state: an accepted aborted packet stops further intake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORMAL: if (wr_fire && i_wr_abort) state_d = DRAIN;
      DRAIN:  state_d = DRAIN;
      default: state_d = NORMAL;
    endcase
    if (i_clear) state_d = NORMAL;
  end

  // Pointer and state registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= NORMAL;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
    end
  end

  // Payload array; zeroed on reset so the head is never X.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_fire && !i_clear) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_pkt;
    end
  end

endmodule

// File: tb/tb_zap_fetch_queue.sv
// Directed table-driven bench for zap_fetch_queue plus a streaming wrap check.
module tb_zap_fetch_queue;

  logic        i_clk = 1'b0;
  logic        i_reset, i_clear, i_wr_valid, i_wr_abort, i_rd_ready;
  logic [31:0] i_wr_instruction, i_wr_pc, i_wr_pc_plus_8;
  logic [1:0]  i_wr_taken;
  logic        o_wr_ready, o_rd_valid, o_rd_abort;
  logic [31:0] o_rd_instruction, o_rd_pc, o_rd_pc_plus_8;
  logic [1:0]  o_rd_taken;
  logic [2:0]  o_level;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  zap_fetch_queue #(.DEPTH(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_instruction(i_wr_instruction), .i_wr_abort(i_wr_abort),
    .i_wr_pc(i_wr_pc), .i_wr_pc_plus_8(i_wr_pc_plus_8), .i_wr_taken(i_wr_taken),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
    .o_rd_instruction(o_rd_instruction), .o_rd_abort(o_rd_abort),
    .o_rd_pc(o_rd_pc), .o_rd_pc_plus_8(o_rd_pc_plus_8), .o_rd_taken(o_rd_taken),
    .o_level(o_level)
  );

  // Instruction word derived from the PC; zero PC gives zero so reset rows fit.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[7:0], pc[15:8], pc[23:16], pc[31:24]} ^ pc;
  endfunction

  typedef struct {
    string       name;
    logic        rst, clr, wv, rr, ab;
    logic [31:0] pc;
    logic        e_wrdy, e_rval;
    logic [2:0]  e_lvl;
    logic        chk;     // compare head payload
    logic [31:0] e_pc;
    logic        e_ab;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(string name, logic rst, logic clr, logic wv, logic rr,
                              logic [31:0] pc, logic ab, logic e_wrdy, logic e_rval,
                              logic [2:0] e_lvl, logic chk, logic [31:0] e_pc, logic e_ab);
    vec_t v;
    v.name = name; v.rst = rst; v.clr = clr; v.wv = wv; v.rr = rr; v.pc = pc; v.ab = ab;
    v.e_wrdy = e_wrdy; v.e_rval = e_rval; v.e_lvl = e_lvl; v.chk = chk; v.e_pc = e_pc;
    v.e_ab = e_ab;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic clr, logic wv, logic rr, logic [31:0] pc, logic ab);
    i_reset          = rst;
    i_clear          = clr;
    i_wr_valid       = wv;
    i_rd_ready       = rr;
    i_wr_pc          = pc;
    i_wr_abort       = ab;
    i_wr_instruction = instr_of(pc);
    i_wr_pc_plus_8   = pc + 32'd8;
    i_wr_taken       = pc[3:2];
  endtask

  initial begin
    int sent, got;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge i_clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("reset wr_ready", o_wr_ready, 1);
    chk("reset rd_valid", o_rd_valid, 0);
    chk("reset level", o_level, 0);
    chk("reset instruction", o_rd_instruction, 0);
    chk("reset pc_plus_8", o_rd_pc_plus_8, 0);

    // Expected values are the outputs seen before the edge that applies the row.
    //          name     rst  clr  wv   rr   pc         ab   wrdy val  lvl  chk  e_pc       e_ab
    // fill to full, held fifth write, read-while-full
    tv.push_back(mk("f0", 0,0,1,0, 32'h000, 0, 1,0,3'd0, 1, 32'h000, 0));
    tv.push_back(mk("f1", 0,0,1,0, 32'h004, 0, 1,1,3'd1, 1, 32'h000, 0));
    tv.push_back(mk("f2", 0,0,1,0, 32'h008, 0, 1,1,3'd2, 1, 32'h000, 0));
    tv.push_back(mk("f3", 0,0,1,0, 32'h00C, 0, 1,1,3'd3, 1, 32'h000, 0));
    tv.push_back(mk("f4", 0,0,1,0, 32'h010, 0, 0,1,3'd4, 1, 32'h000, 0));
    tv.push_back(mk("f5", 0,0,1,1, 32'h010, 0, 0,1,3'd4, 1, 32'h000, 0));
    tv.push_back(mk("f6", 0,0,0,1, 32'h000, 0, 1,1,3'd3, 1, 32'h004, 0));
    tv.push_back(mk("f7", 0,0,0,1, 32'h000, 0, 1,1,3'd2, 1, 32'h008, 0));
    tv.push_back(mk("f8", 0,0,0,1, 32'h000, 0, 1,1,3'd1, 1, 32'h00C, 0));
    tv.push_back(mk("f9", 0,0,0,0, 32'h000, 0, 1,0,3'd0, 0, 32'h000, 0));
    // abort enters drain; drain survives empty until clear
    tv.push_back(mk("a0", 0,0,1,0, 32'h200, 0, 1,0,3'd0, 0, 32'h000, 0));
    tv.push_back(mk("a1", 0,0,1,0, 32'h204, 1, 1,1,3'd1, 1, 32'h200, 0));
    tv.push_back(mk("a2", 0,0,1,1, 32'h208, 0, 0,1,3'd2, 1, 32'h200, 0));
    tv.push_back(mk("a3", 0,0,1,1, 32'h20C, 0, 0,1,3'd1, 1, 32'h204, 1));
    tv.push_back(mk("a4", 0,0,0,0, 32'h000, 0, 0,0,3'd0, 0, 32'h000, 0));
    tv.push_back(mk("a5", 0,1,0,0, 32'h000, 0, 0,0,3'd0, 0, 32'h000, 0));
    tv.push_back(mk("a6", 0,0,0,0, 32'h000, 0, 1,0,3'd0, 0, 32'h000, 0));
    // clear with simultaneous write and read
    tv.push_back(mk("c0", 0,0,1,0, 32'h300, 0, 1,0,3'd0, 0, 32'h000, 0));
    tv.push_back(mk("c1", 0,0,1,0, 32'h304, 0, 1,1,3'd1, 1, 32'h300, 0));
    tv.push_back(mk("c2", 0,0,1,0, 32'h308, 0, 1,1,3'd2, 1, 32'h300, 0));
    tv.push_back(mk("c3", 0,1,1,1, 32'h30C, 0, 1,1,3'd3, 1, 32'h300, 0));
    tv.push_back(mk("c4", 0,0,0,0, 32'h000, 0, 1,0,3'd0, 0, 32'h000, 0));
    tv.push_back(mk("c5", 0,0,1,0, 32'h310, 0, 1,0,3'd0, 0, 32'h000, 0));
    tv.push_back(mk("c6", 0,0,0,1, 32'h000, 0, 1,1,3'd1, 1, 32'h310, 0));
    // reset while in drain with two entries
    tv.push_back(mk("r0", 0,0,1,0, 32'h400, 0, 1,0,3'd0, 0, 32'h000, 0));
    tv.push_back(mk("r1", 0,0,1,0, 32'h404, 1, 1,1,3'd1, 1, 32'h400, 0));
    tv.push_back(mk("r2", 1,0,0,0, 32'h000, 0, 0,1,3'd2, 1, 32'h400, 0));
    tv.push_back(mk("r3", 0,0,0,0, 32'h000, 0, 1,0,3'd0, 1, 32'h000, 0));

    foreach (tv[k]) begin
      @(negedge i_clk);
      drive(tv[k].rst, tv[k].clr, tv[k].wv, tv[k].rr, tv[k].pc, tv[k].ab);
      #1;
      chk({tv[k].name, " wr_ready"}, o_wr_ready, tv[k].e_wrdy);
      chk({tv[k].name, " rd_valid"}, o_rd_valid, tv[k].e_rval);
      chk({tv[k].name, " level"}, o_level, tv[k].e_lvl);
      if (tv[k].chk) begin
        chk({tv[k].name, " rd_pc"}, o_rd_pc, tv[k].e_pc);
        chk({tv[k].name, " rd_abort"}, o_rd_abort, tv[k].e_ab);
        chk({tv[k].name, " rd_instr"}, o_rd_instruction, instr_of(tv[k].e_pc));
        chk({tv[k].name, " rd_taken"}, o_rd_taken, tv[k].e_pc[3:2]);
        if (tv[k].e_rval)
          chk({tv[k].name, " rd_pc8"}, o_rd_pc_plus_8, tv[k].e_pc + 32'd8);
      end
    end

    // Streaming through several wraps with random consumer stalls.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      @(negedge i_clk);
      drive(1'b0, 1'b0, sent < 20, 1'($urandom_range(0, 1)), 32'h100 + 32'(4 * sent), 1'b0);
      #1;
      chk("stream level<=4", {31'd0, o_level > 3'd4}, 0);
      if (o_rd_valid && i_rd_ready) begin
        chk("stream rd_pc", o_rd_pc, 32'h100 + 32'(4 * got));
        got++;
      end
      if (i_wr_valid && o_wr_ready) sent++;
    end
    chk("stream packets out", got, 20);
    @(negedge i_clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("stream drained level", o_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/zap_fetch_queue.md
Name: zap_fetch_queue

Overview:
- Decoupling instruction queue between the fetch stage and decode.
- Buffers fetched instruction packets so short decode/issue stalls do not idle the I-cache, and vice versa.
- Each packet carries: instruction, abort flag, PC, PC+8 and the 2-bit branch-prediction state.
- Flushed on any pipeline clear. Enters drain mode after accepting an aborted packet, matching the fetch sleep behaviour.

Parameters:
DEPTH, 4, number of packet entries; power of two, >= 2.

Ports:
i_clk  in  1  clock.
i_reset  in  1  reset; synchronous, active-high.
i_clear  in  1  flush (OR of writeback/ALU/decode clears, externally combined).
i_wr_valid  in  1  fetch presents a packet.
o_wr_ready  out  1  queue can accept; equals !full && state==NORMAL.
i_wr_instruction  in  32  instruction.
i_wr_abort  in  1  instruction abort.
i_wr_pc  in  32  PC of instruction.
i_wr_pc_plus_8  in  32  PC+8 (or +4 in Thumb).
i_wr_taken  in  2  predictor state.
o_rd_valid  out  1  head packet valid (= !empty).
i_rd_ready  in  1  decode consumes the head packet.
o_rd_instruction  out  32  head instruction.
o_rd_abort  out  1  head abort.
o_rd_pc  out  32  head PC.
o_rd_pc_plus_8  out  32  head PC+8.
o_rd_taken  out  2  head predictor state.
o_level  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Storage:
  - DEPTH x 99-bit payload array.
  - Write pointer and read pointer, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Empty: pointers equal. Full: low bits equal and MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Show-ahead read: o_rd_* are driven combinationally from array[rd_ptr]. Payload outputs are don't-care when o_rd_valid=0, but must not be X after reset (array reset to 0).
- Write: when i_wr_valid && o_wr_ready, the packet is stored at wr_ptr and wr_ptr increments.
  - Latency write→o_rd_valid is 1 cycle. There is no bypass.
  - i_wr_valid while o_wr_ready=0: ignored; upstream holds the packet.
- Read: when o_rd_valid && i_rd_ready, rd_ptr increments. i_rd_ready while empty: no effect.
- Simultaneous read and write: both happen and level is unchanged.
  - o_wr_ready depends only on registered state, never on i_rd_ready. When full, a same-cycle read does not enable a write.
- o_level = wr_ptr - rd_ptr, with width $clog2(DEPTH)+1. Ranges 0..DEPTH.
- State machine, 2 states:
  - NORMAL: writes are allowed subject to not being full. Accepting a write with i_wr_abort=1 → DRAIN.
  - DRAIN: o_wr_ready=0 and reads continue normally. Stays in DRAIN, even when empty, until i_clear → NORMAL.
- i_clear (priority below reset, above everything else):
  - Next cycle: rd_ptr=wr_ptr=0, state=NORMAL, o_rd_valid=0, o_level=0.
  - A write and/or read in the same cycle as i_clear is discarded.
- Reset values: pointers 0, state NORMAL, array 0.
  - Resulting outputs: o_rd_valid=0, o_wr_ready=1, o_level=0, all o_rd_* = 0.
  - Reset mid-operation discards all contents identically.
- The abort flag is carried verbatim. The queue does not inspect instruction contents.

Decomposition:
- Shared package zap_fetch_queue_pkg holds:
  - packet struct typedef (instruction, abort, pc, pc_plus_8, taken);
  - state enum {NORMAL, DRAIN}.
- No sub-module. Pointer/flag logic and the array live in one module. The array is a plain register array (no zap_ram_simple_nopipe), because the head must be read combinationally.

Test Plan:
1. Reset, then write 4 packets with PC 0x0,0x4,0x8,0xC and no reads → o_level 1..4. o_wr_ready=0 after the 4th. A 5th write with PC 0x10 is held and not stored.
2. From full, assert i_rd_ready and i_wr_valid together → one read (head PC 0x0). No write that cycle; next cycle o_wr_ready=1, o_level=3.
3. Wrap-around: stream 20 packets (PC 0x100+4n) with i_rd_ready toggled pseudo-randomly → output PC sequence strictly 0x100,0x104,… with no loss or duplication. o_level is never >4.
4. Write PC 0x200 with abort=0, then PC 0x204 with abort=1 → o_wr_ready drops the next cycle. Both packets are read out, the second with o_rd_abort=1. o_wr_ready stays 0 while empty until i_clear, then returns to 1.
5. With 3 entries, assert i_clear together with i_wr_valid and i_rd_ready → next cycle o_level=0, o_rd_valid=0. The written packet never appears.
6. Reset asserted with 2 entries in DRAIN → next cycle o_level=0, o_wr_ready=1, o_rd_instruction=0.
